ab_stim_gen: RTL and testbench

AB_STIM_GEN -- requirements
Module: ab_stim_gen

---
 rtl/ab_stim_gen.sv | 111 +++++++++++
 tb/tb_ab_stim_gen.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ab_stim_gen.sv
// ab_stim_gen: drives a request/acknowledge (a/b) strobe pattern toward a
// downstream protocol checker. Each transaction is one cycle of a followed
// by one cycle of b, separated from the next by a programmable idle gap.
// The b of the final transaction can be suppressed to provoke a checker error.
module ab_stim_gen #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_req,
  input  logic [GAP_W-1:0] gap,
  input  logic             inject_err,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] req_cnt,
  output logic [CNT_W-1:0] ack_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_ACK  = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;

  // Parameters of the running sequence, captured when start is accepted.
  logic [CNT_W-1:0] remaining;
  logic [GAP_W-1:0] gap_lat;
  logic             err_lat;
  logic [GAP_W-1:0] gap_cnt;

  logic             accept;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return CNT_W'(v + 1'b1);
  endfunction

  assign accept = (state == ST_IDLE) && start;

  // Strobes come purely from registered state so they never follow an input
  // combinationally; b is withheld only in the last ACK of an error run.
  assign a    = (state == ST_REQ);
  assign b    = (state == ST_ACK) && !(err_lat && (remaining == '0));
  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  // State register; reset aborts any sequence immediately and beats start.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nxt = (num_req != '0) ? ST_REQ : ST_DONE;
      end
      ST_REQ:  state_nxt = ST_ACK;
      ST_ACK: begin
        if (remaining == '0)    state_nxt = ST_DONE;
        else if (gap_lat == '0) state_nxt = ST_REQ;
        else                    state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt <= GAP_W'(1)) state_nxt = ST_REQ;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Sequence bookkeeping: latch on accept, count down transactions and gap.
  always_ff @(posedge clk) begin
    if (accept) begin
      remaining <= num_req;
      gap_lat   <= gap;
      err_lat   <= inject_err;
    end else if (state == ST_REQ) begin
      remaining <= CNT_W'(remaining - 1'b1);
    end
    if (state == ST_ACK)      gap_cnt <= gap_lat;
    else if (state == ST_GAP) gap_cnt <= GAP_W'(gap_cnt - 1'b1);
  end

  // Strobe counters, cleared by reset and by each accepted start.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      req_cnt <= '0;
      ack_cnt <= '0;
    end else if (accept) begin
      req_cnt <= '0;
      ack_cnt <= '0;
    end else begin
      if (a) req_cnt <= sat_inc(req_cnt);
      if (b) ack_cnt <= sat_inc(ack_cnt);
    end
  end

endmodule

// File: tb/tb_ab_stim_gen.sv
// Bench for ab_stim_gen: directed and randomized sequences compared cycle by
// cycle against a timing model derived from the transaction arithmetic.
module tb_ab_stim_gen;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] num_req;
  logic [3:0] gap;
  logic       inject_err;
  logic       a, b, busy, done;
  logic [7:0] req_cnt, ack_cnt;

  int compared   = 0;
  int mismatched = 0;

  ab_stim_gen #(.CNT_W(8), .GAP_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_req(num_req),
    .gap(gap), .inject_err(inject_err), .a(a), .b(b), .busy(busy),
    .done(done), .req_cnt(req_cnt), .ack_cnt(ack_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Cycle of the done pulse when start is accepted at the edge ending cycle 0.
  function automatic int done_cycle(input int n, input int g);
    if (n == 0) return 1;
    return 1 + 2 * n + (n - 1) * g;
  endfunction

  // Expected {a, b, done, busy} in cycle k: transaction i has a at
  // 1 + i*(2+g) and b one cycle later; the last b is dropped on error.
  function automatic logic [3:0] model(input int n, input int g, input bit e, input int k);
    int d, per, off, idx;
    logic ea, eb;
    d  = done_cycle(n, g);
    per = 2 + g;
    ea = 1'b0;
    eb = 1'b0;
    if (k >= 1 && k < d) begin
      off = (k - 1) % per;
      idx = (k - 1) / per;
      ea  = (off == 0);
      eb  = (off == 1) && !(e && idx == n - 1);
    end
    return {ea, eb, (k == d), (k >= 1 && k <= d)};
  endfunction

  task automatic check_cycle(input string tag, input logic [3:0] m, input int er, input int ea);
    check({tag, ".a"},       32'(a),       32'(m[3]));
    check({tag, ".b"},       32'(b),       32'(m[2]));
    check({tag, ".done"},    32'(done),    32'(m[1]));
    check({tag, ".busy"},    32'(busy),    32'(m[0]));
    check({tag, ".req_cnt"}, 32'(req_cnt), 32'(er));
    check({tag, ".ack_cnt"}, 32'(ack_cnt), 32'(ea));
  endtask

  // Call at a negedge with the DUT idle; start is accepted at the next edge.
  // While busy the inputs are scrambled (including num_req=9) to show they
  // are ignored; the cycle after done is left idle for the next start.
  task automatic run_seq(input int n, input int g, input bit e);
    int d, er, ea, miss;
    logic [3:0] m;
    logic pa;
    d = done_cycle(n, g);
    start = 1'b1; num_req = 8'(n); gap = 4'(g); inject_err = e;
    er = 0; ea = 0; miss = 0; pa = 1'b0;
    for (int k = 1; k <= d + 1; k++) begin
      @(negedge clk);
      m = model(n, g, e, k);
      check_cycle($sformatf("seq%0d_%0d_%0d.c%0d", n, g, e, k), m, er, ea);
      if (pa && !b) miss++;
      pa = a;
      er += int'(m[3]);
      ea += int'(m[2]);
      if (k <= d) begin
        start = 1'($urandom_range(0, 1)); num_req = 8'd9;
        gap = 4'($urandom_range(0, 15)); inject_err = 1'($urandom_range(0, 1));
      end
      if (k == d + 1 || k == d) begin
        start = 1'b0; num_req = '0; gap = '0; inject_err = 1'b0;
      end
    end
    check($sformatf("seq%0d_%0d_%0d.missed_b", n, g, e), 32'(miss), (e && n > 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    logic [3:0] m;
    int er;
    reset_n = 1'b0; start = 1'b1; num_req = 8'd3; gap = '0; inject_err = 1'b0;
    repeat (3) @(negedge clk);
    check_cycle("reset", 4'b0000, 0, 0);
    reset_n = 1'b1; start = 1'b0;
    @(negedge clk);
    check_cycle("post_reset_idle", 4'b0000, 0, 0);

    run_seq(3, 0, 1'b0);
    run_seq(2, 2, 1'b0);
    run_seq(2, 0, 1'b1);
    run_seq(0, 0, 1'b0);
    run_seq(0, 3, 1'b1);
    run_seq(1, 0, 1'b1);
    run_seq(4, 1, 1'b0);

    // Reset in the middle of a 5-transaction run, with start also asserted.
    start = 1'b1; num_req = 8'd5; gap = '0; inject_err = 1'b0;
    er = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      m = model(5, 0, 1'b0, k);
      check_cycle($sformatf("abort.c%0d", k), m, er, (k - 1) / 2);
      er += int'(m[3]);
      start = 1'b0;
      if (k == 4) begin
        reset_n = 1'b0; start = 1'b1; num_req = 8'd3;
      end
    end
    @(negedge clk);
    check_cycle("abort.c5", 4'b0000, 0, 0);
    reset_n = 1'b1; start = 1'b0;
    @(negedge clk);
    check_cycle("abort.c6", 4'b0000, 0, 0);

    for (int r = 0; r < 12; r++) begin
      run_seq(int'($urandom_range(0, 10)), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
